net_ingress_dispatch: RTL and testbench
=======================================

# net_ingress_dispatch

Parametrised network-packet ingress unit for the core: accepts `net_packet_s`-format packets from the on-chip network, filters them by core ID, buffers them in a FIFO and dispatches each one to the instruction-memory, register-file, PC or barrier-mask write port. It generalises the single-slot packet handling with configurable ID, FIFO, address and mask widths. It adds per-channel back-pressure, head-of-line ordering and a dropped-packet counter. It sits between the network interface and the core datapath/controller.

## Interface
- `ID_W`, 10, width of packet ID field.
- `FIFO_DEPTH`, 4, buffered packets; power of 2, ≥2.
- `IMEM_ADDR_W`, 10, instruction-memory address width.
- `RF_ADDR_W`, 5, register-file address width.
- `MASK_W`, 3, barrier mask width.
- Derived `PKT_W` = `ID_W`+3+6+14+32; field order MSB→LSB: ID, net_op, reserved, net_addr, net_data.

Ports:
- `clk` in 1: single clock, rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `core_id_i` in `ID_W`: this core's ID.
- `core_state_i` in 2: controller state; IDLE=00, RUN=01, ERR=11.
- `net_v_i` in 1: input packet valid.
- `net_packet_i` in `PKT_W`: input packet.
- `net_ready_o` out 1: FIFO can accept.
- `rf_ready_i` in 1: register write port free this cycle.
- `imem_wen_o` out 1; `imem_addr_o` out `IMEM_ADDR_W`; `imem_wdata_o` out 16.
- `rf_wen_o` out 1; `rf_addr_o` out `RF_ADDR_W`; `rf_wdata_o` out 32.
- `pc_wen_o` out 1; `pc_o` out `IMEM_ADDR_W`.
- `bar_wen_o` out 1; `bar_mask_o` out `MASK_W`.
- `drop_count_o` out 8: saturating count of discarded packets.
- `fifo_count_o` out `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- Enqueue when `net_v_i && net_ready_o`.
- Filter at enqueue. Packets are discarded and do not enter the FIFO if either condition holds:
  - ID ≠ `core_id_i`, except broadcast (see Configuration).
  - net_op ∈ {NULL=000, 101, 110, 111}.
- A discarded packet increments `drop_count_o`, which saturates at 255. Discarding consumes the handshake, so `net_ready_o` still gates it.
- `net_ready_o` = occupancy < `FIFO_DEPTH`. It is derived from registered occupancy only, with no full-FIFO pass-through.
- Dispatch examines the head packet and issues at most one packet per cycle, in strict order. A head that cannot issue blocks all entries behind it.
  - INSTR (001): issues only when `core_state_i`==IDLE. `imem_addr_o`=net_addr[`IMEM_ADDR_W`-1:0], `imem_wdata_o`=net_data[15:0].
  - REG (010): issues when `rf_ready_i`. `rf_addr_o`=net_addr[`RF_ADDR_W`-1:0], `rf_wdata_o`=net_data.
  - PC (011): issues only when `core_state_i`==IDLE. `pc_o`=net_addr[`IMEM_ADDR_W`-1:0].
  - BAR (100): issues unconditionally. `bar_mask_o`=net_data[`MASK_W`-1:0].
- Issue pops the head. The matching `*_wen_o` is a registered one-cycle pulse, and its data outputs are registered with it.
- Data outputs hold their last issued value between pulses.
- Pointers wrap modulo `FIFO_DEPTH`. Simultaneous enqueue and pop leaves occupancy unchanged. When the FIFO is empty, pop does not occur.
- Reset, asserted at any time including mid-dispatch, has these effects:
  - FIFO is flushed.
  - All `*_wen_o` go low.
  - All data outputs, `drop_count_o` and `fifo_count_o` are cleared to 0.
  - `net_ready_o` goes to 1 once reset is released.

## Timing
- A packet accepted at edge N is at the FIFO head from N+1. If it is eligible in that cycle, its `*_wen_o` is high during cycle N+1→N+2. Minimum latency is one cycle from the accept edge to the strobe.
- Sustained throughput is 1 packet/cycle when every head is eligible.
- `drop_count_o` updates at the accept edge.
- `fifo_count_o` and `net_ready_o` update at the edge following the enqueue or pop.
- `core_state_i` and `rf_ready_i` are sampled combinationally in the cycle before the issuing edge.

## Configuration
- `NET_BROADCAST_EN` defined: a packet with ID = all ones is accepted by every core regardless of `core_id_i`.
- `NET_BROADCAST_EN` undefined: an all-ones ID is treated like any other ID. It is accepted only if `core_id_i` is all ones; otherwise it is dropped and counted.

## Test plan
- Filter and order: `core_id_i`=5; send REG(addr 3, data 0xDEADBEEF) with ID 5, then with ID 6 → one `rf_wen_o` pulse with `rf_addr_o`=3, `rf_wdata_o`=0xDEADBEEF; `drop_count_o`=1.
- State gating: `core_state_i`=RUN; send INSTR(addr 0x12, data 0xA5C3) then BAR(mask 3'b101) → BAR blocked and no strobes; set IDLE → `imem_wen_o` pulse (0x12, 0xA5C3), then `bar_wen_o` pulse with 3'b101 on the next cycle.
- Full and back-pressure: hold `rf_ready_i`=0 and send 5 REG packets back-to-back → 4 accepted, `net_ready_o`=0, `fifo_count_o`=4; release → 4 `rf_wen_o` pulses on consecutive cycles, in order.
- Reserved op and saturation: send 300 packets with net_op=110 → no strobes; `drop_count_o`=255.
- Broadcast: ID=0x3FF PC(addr 0x40), `core_id_i`=5, IDLE → with macro `pc_wen_o` pulse with `pc_o`=0x40; without macro no pulse and `drop_count_o`=1.
- Reset mid-operation: fill 3 entries, assert `n_reset` between edges → immediately all outputs 0 and `fifo_count_o`=0; after release no stale strobes appear.

Source files
------------

// File: rtl/net_ingress_dispatch.sv
// ============================================================================
// Module  : net_ingress_dispatch
// Filters network packets by core ID, buffers them in a FIFO and dispatches
// the head packet to the imem / register-file / PC / barrier write ports.
// Optional macro: NET_BROADCAST_EN (all-ones ID is accepted by every core)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module net_ingress_dispatch #(
  parameter int ID_W        = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int IMEM_ADDR_W = 10,
  parameter int RF_ADDR_W   = 5,
  parameter int MASK_W      = 3,
  localparam int PKT_W      = ID_W + 3 + 6 + 14 + 32,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [ID_W-1:0]        core_id_i,
  input  logic [1:0]             core_state_i,
  input  logic                   net_v_i,
  input  logic [PKT_W-1:0]       net_packet_i,
  output logic                   net_ready_o,
  input  logic                   rf_ready_i,
  output logic                   imem_wen_o,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  output logic [15:0]            imem_wdata_o,
  output logic                   rf_wen_o,
  output logic [RF_ADDR_W-1:0]   rf_addr_o,
  output logic [31:0]            rf_wdata_o,
  output logic                   pc_wen_o,
  output logic [IMEM_ADDR_W-1:0] pc_o,
  output logic                   bar_wen_o,
  output logic [MASK_W-1:0]      bar_mask_o,
  output logic [7:0]             drop_count_o,
  output logic [CNT_W-1:0]       fifo_count_o
);

  localparam int             c_AW       = $clog2(FIFO_DEPTH);
  localparam int             c_ENT_W    = 3 + 14 + 32;
  localparam logic [CNT_W-1:0] c_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]     c_OP_INSTR = 3'b001;
  localparam logic [2:0]     c_OP_REG   = 3'b010;
  localparam logic [2:0]     c_OP_PC    = 3'b011;
  localparam logic [2:0]     c_OP_BAR   = 3'b100;
  localparam logic [1:0]     c_ST_IDLE  = 2'b00;

  logic [ID_W-1:0]    w_in_id;
  logic [2:0]         w_in_op;
  logic [13:0]        w_in_addr;
  logic [31:0]        w_in_data;
  logic               w_id_ok;
  logic               w_op_ok;
  logic               w_accept;
  logic               w_push;
  logic               w_drop;
  logic               w_empty;
  logic               w_elig;
  logic               w_pop;
  logic [c_ENT_W-1:0] w_head;
  logic [2:0]         w_head_op;
  logic [13:0]        w_head_addr;
  logic [31:0]        w_head_data;
  logic               w_unused_bits;

  logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr;
  logic [c_AW-1:0]      r_rd;
  logic [CNT_W-1:0]     r_count;
  logic [7:0]           r_drop;
  logic                 r_imem_wen;
  logic [IMEM_ADDR_W-1:0] r_imem_addr;
  logic [15:0]          r_imem_wdata;
  logic                 r_rf_wen;
  logic [RF_ADDR_W-1:0] r_rf_addr;
  logic [31:0]          r_rf_wdata;
  logic                 r_pc_wen;
  logic [IMEM_ADDR_W-1:0] r_pc;
  logic                 r_bar_wen;
  logic [MASK_W-1:0]    r_bar_mask;

  assign w_in_id   = net_packet_i[PKT_W-1 -: ID_W];
  assign w_in_op   = net_packet_i[54:52];
  assign w_in_addr = net_packet_i[45:32];
  assign w_in_data = net_packet_i[31:0];

`ifdef NET_BROADCAST_EN
  assign w_id_ok = (w_in_id == core_id_i) || (&w_in_id);
`else
  assign w_id_ok = (w_in_id == core_id_i);
`endif

  assign w_op_ok  = (w_in_op == c_OP_INSTR) || (w_in_op == c_OP_REG) ||
                    (w_in_op == c_OP_PC)    || (w_in_op == c_OP_BAR);
  assign net_ready_o = (r_count < c_FULL);
  assign w_accept = net_v_i && net_ready_o;
  assign w_push   = w_accept && w_id_ok && w_op_ok;
  assign w_drop   = w_accept && !(w_id_ok && w_op_ok);

  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd];
  assign w_head_op   = w_head[c_ENT_W-1 -: 3];
  assign w_head_addr = w_head[45:32];
  assign w_head_data = w_head[31:0];

  // Reserved field and high address bits never reach any write port.
  assign w_unused_bits = ^{net_packet_i[51:46], w_head_addr};

  always_comb begin
    w_elig = 1'b0;
    case (w_head_op)
      c_OP_INSTR: w_elig = (core_state_i == c_ST_IDLE);
      c_OP_REG:   w_elig = rf_ready_i;
      c_OP_PC:    w_elig = (core_state_i == c_ST_IDLE);
      c_OP_BAR:   w_elig = 1'b1;
      default:    w_elig = 1'b0;
    endcase
  end

  assign w_pop = !w_empty && w_elig;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= {w_in_op, w_in_addr, w_in_data};
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + c_AW'(1);
      if (w_pop)  r_rd <= r_rd + c_AW'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // Strobes are one-cycle pulses; data registers hold until the next issue.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_imem_wen   <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_rf_wen     <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_wdata   <= '0;
      r_pc_wen     <= 1'b0;
      r_pc         <= '0;
      r_bar_wen    <= 1'b0;
      r_bar_mask   <= '0;
    end else begin
      r_imem_wen <= w_pop && (w_head_op == c_OP_INSTR);
      r_rf_wen   <= w_pop && (w_head_op == c_OP_REG);
      r_pc_wen   <= w_pop && (w_head_op == c_OP_PC);
      r_bar_wen  <= w_pop && (w_head_op == c_OP_BAR);
      if (w_pop && (w_head_op == c_OP_INSTR)) begin
        r_imem_addr  <= w_head_addr[IMEM_ADDR_W-1:0];
        r_imem_wdata <= w_head_data[15:0];
      end
      if (w_pop && (w_head_op == c_OP_REG)) begin
        r_rf_addr  <= w_head_addr[RF_ADDR_W-1:0];
        r_rf_wdata <= w_head_data;
      end
      if (w_pop && (w_head_op == c_OP_PC)) begin
        r_pc <= w_head_addr[IMEM_ADDR_W-1:0];
      end
      if (w_pop && (w_head_op == c_OP_BAR)) begin
        r_bar_mask <= w_head_data[MASK_W-1:0];
      end
    end
  end

  assign imem_wen_o   = r_imem_wen;
  assign imem_addr_o  = r_imem_addr;
  assign imem_wdata_o = r_imem_wdata;
  assign rf_wen_o     = r_rf_wen;
  assign rf_addr_o    = r_rf_addr;
  assign rf_wdata_o   = r_rf_wdata;
  assign pc_wen_o     = r_pc_wen;
  assign pc_o         = r_pc;
  assign bar_wen_o    = r_bar_wen;
  assign bar_mask_o   = r_bar_mask;
  assign drop_count_o = r_drop;
  assign fifo_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_net_ingress_dispatch.sv
// ============================================================================
// Module  : tb_net_ingress_dispatch
// Directed self-checking bench for net_ingress_dispatch (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_net_ingress_dispatch;

  logic        clk;
  logic        n_reset;
  logic [9:0]  core_id;
  logic [1:0]  core_state;
  logic        net_v;
  logic [64:0] net_packet;
  logic        net_ready;
  logic        rf_ready;
  logic        imem_wen;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        pc_wen;
  logic [9:0]  pc;
  logic        bar_wen;
  logic [2:0]  bar_mask;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  net_ingress_dispatch dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .core_id_i    (core_id),
    .core_state_i (core_state),
    .net_v_i      (net_v),
    .net_packet_i (net_packet),
    .net_ready_o  (net_ready),
    .rf_ready_i   (rf_ready),
    .imem_wen_o   (imem_wen),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .rf_wen_o     (rf_wen),
    .rf_addr_o    (rf_addr),
    .rf_wdata_o   (rf_wdata),
    .pc_wen_o     (pc_wen),
    .pc_o         (pc),
    .bar_wen_o    (bar_wen),
    .bar_mask_o   (bar_mask),
    .drop_count_o (drop_count),
    .fifo_count_o (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] mk(input logic [9:0] id, input logic [2:0] op,
                                     input logic [13:0] addr, input logic [31:0] data);
    return {id, op, 6'b0, addr, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    net_v   = 1'b0;
    n_reset = 1'b0;
    step();
    step();
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    n_reset = 1'b0; net_v = 1'b0; core_id = 10'd5; core_state = 2'b00;
    rf_ready = 1'b1; net_packet = '0;
    step();
    step();
    n_checks++; if ({imem_wen, rf_wen, pc_wen, bar_wen} !== 4'b0) $display("FAIL reset_wen got %b want 0000", {imem_wen, rf_wen, pc_wen, bar_wen}); else n_pass++;
    n_checks++; if ({imem_addr, imem_wdata, rf_addr, rf_wdata, pc, bar_mask} !== '0) $display("FAIL reset_data got nonzero want 0"); else n_pass++;
    n_checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_count); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else n_pass++;
    n_reset = 1'b1;
    step();
    n_checks++; if (net_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", net_ready); else n_pass++;
  endtask

  task automatic test_filter();
    do_reset();
    core_id = 10'd5; core_state = 2'b00; rf_ready = 1'b1;
    net_v = 1'b1;
    net_packet = mk(10'd5, 3'b010, 14'd3, 32'hDEADBEEF);
    step();
    n_checks++; if (fifo_count !== 3'd1) $display("FAIL filter_count1 got %0d want 1", fifo_count); else n_pass++;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL filter_early_wen got %b want 0", rf_wen); else n_pass++;
    net_packet = mk(10'd6, 3'b010, 14'd9, 32'h11111111);
    step();
    n_checks++; if (rf_wen !== 1'b1) $display("FAIL filter_rf_wen got %b want 1", rf_wen); else n_pass++;
    n_checks++; if (rf_addr !== 5'd3) $display("FAIL filter_rf_addr got %0d want 3", rf_addr); else n_pass++;
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL filter_rf_wdata got %h want deadbeef", rf_wdata); else n_pass++;
    n_checks++; if (drop_count !== 8'd1) $display("FAIL filter_drop got %0d want 1", drop_count); else n_pass++;
    net_v = 1'b0;
    step();
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL filter_pulse_end got %b want 0", rf_wen); else n_pass++;
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL filter_hold got %h want deadbeef", rf_wdata); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL filter_count0 got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_state_gating();
    logic [3:0] any;
    do_reset();
    core_id = 10'd5; core_state = 2'b01; rf_ready = 1'b1;
    net_v = 1'b1;
    net_packet = mk(10'd5, 3'b001, 14'h12, 32'h0000A5C3);
    step();
    net_packet = mk(10'd5, 3'b100, 14'h0, 32'h5);
    step();
    net_v = 1'b0;
    any = '0;
    for (int i = 0; i < 3; i++) begin
      any |= {imem_wen, rf_wen, pc_wen, bar_wen};
      step();
    end
    any |= {imem_wen, rf_wen, pc_wen, bar_wen};
    n_checks++; if (any !== 4'b0) $display("FAIL gate_blocked got %b want 0000", any); else n_pass++;
    n_checks++; if (fifo_count !== 3'd2) $display("FAIL gate_count got %0d want 2", fifo_count); else n_pass++;
    core_state = 2'b00;
    step();
    n_checks++; if ({imem_wen, bar_wen} !== 2'b10) $display("FAIL gate_imem_wen got %b want 10", {imem_wen, bar_wen}); else n_pass++;
    n_checks++; if (imem_addr !== 10'h12) $display("FAIL gate_imem_addr got %h want 012", imem_addr); else n_pass++;
    n_checks++; if (imem_wdata !== 16'hA5C3) $display("FAIL gate_imem_wdata got %h want a5c3", imem_wdata); else n_pass++;
    step();
    n_checks++; if ({imem_wen, bar_wen} !== 2'b01) $display("FAIL gate_bar_wen got %b want 01", {imem_wen, bar_wen}); else n_pass++;
    n_checks++; if (bar_mask !== 3'b101) $display("FAIL gate_bar_mask got %b want 101", bar_mask); else n_pass++;
    step();
    n_checks++; if (bar_wen !== 1'b0) $display("FAIL gate_bar_end got %b want 0", bar_wen); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL gate_count0 got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    core_id = 10'd5; core_state = 2'b00; rf_ready = 1'b0;
    net_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      net_packet = mk(10'd5, 3'b010, 14'(i + 1), 32'hC0DE0000 + 32'(i));
      step();
    end
    n_checks++; if (fifo_count !== 3'd4) $display("FAIL full_count got %0d want 4", fifo_count); else n_pass++;
    n_checks++; if (net_ready !== 1'b0) $display("FAIL full_ready got %b want 0", net_ready); else n_pass++;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL full_wen got %b want 0", rf_wen); else n_pass++;
    n_checks++; if (drop_count !== 8'd0) $display("FAIL full_drop got %0d want 0", drop_count); else n_pass++;
    net_v = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (rf_wen !== 1'b1) $display("FAIL full_drain_wen%0d got %b want 1", i, rf_wen); else n_pass++;
      n_checks++; if (rf_addr !== 5'(i + 1)) $display("FAIL full_drain_addr%0d got %0d want %0d", i, rf_addr, i + 1); else n_pass++;
      n_checks++; if (rf_wdata !== 32'hC0DE0000 + 32'(i)) $display("FAIL full_drain_data%0d got %h want %h", i, rf_wdata, 32'hC0DE0000 + 32'(i)); else n_pass++;
    end
    step();
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL full_drain_end got %b want 0", rf_wen); else n_pass++;
    n_checks++; if ({fifo_count, net_ready} !== {3'd0, 1'b1}) $display("FAIL full_empty got %0d/%b want 0/1", fifo_count, net_ready); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [2:0] ops [3];
    logic [3:0] any;
    ops = '{3'b000, 3'b101, 3'b111};
    do_reset();
    core_id = 10'd5; core_state = 2'b00; rf_ready = 1'b1;
    net_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      net_packet = mk(10'd5, ops[i], 14'd1, 32'd1);
      step();
    end
    n_checks++; if (drop_count !== 8'd3) $display("FAIL sat_badop_drop got %0d want 3", drop_count); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL sat_badop_count got %0d want 0", fifo_count); else n_pass++;
    any = '0;
    for (int i = 0; i < 297; i++) begin
      net_packet = mk(10'd5, 3'b110, 14'(i), 32'(i));
      step();
      any |= {imem_wen, rf_wen, pc_wen, bar_wen};
      if (i == 250) begin
        n_checks++; if (drop_count !== 8'd254) $display("FAIL sat_254 got %0d want 254", drop_count); else n_pass++;
      end
      if (i == 251) begin
        n_checks++; if (drop_count !== 8'd255) $display("FAIL sat_255 got %0d want 255", drop_count); else n_pass++;
      end
    end
    net_v = 1'b0;
    step();
    n_checks++; if (any !== 4'b0) $display("FAIL sat_strobes got %b want 0000", any); else n_pass++;
    n_checks++; if (drop_count !== 8'd255) $display("FAIL sat_final got %0d want 255", drop_count); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL sat_count got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_broadcast();
    do_reset();
    core_id = 10'd5; core_state = 2'b00; rf_ready = 1'b1;
    net_v = 1'b1;
    net_packet = mk(10'h3FF, 3'b011, 14'h40, 32'd0);
    step();
    net_v = 1'b0;
    step();
`ifdef NET_BROADCAST_EN
    n_checks++; if (pc_wen !== 1'b1) $display("FAIL bcast_pc_wen got %b want 1", pc_wen); else n_pass++;
    n_checks++; if (pc !== 10'h40) $display("FAIL bcast_pc got %h want 040", pc); else n_pass++;
    n_checks++; if (drop_count !== 8'd0) $display("FAIL bcast_drop got %0d want 0", drop_count); else n_pass++;
`else
    n_checks++; if (pc_wen !== 1'b0) $display("FAIL bcast_pc_wen got %b want 0", pc_wen); else n_pass++;
    n_checks++; if (pc !== 10'h0) $display("FAIL bcast_pc got %h want 000", pc); else n_pass++;
    n_checks++; if (drop_count !== 8'd1) $display("FAIL bcast_drop got %0d want 1", drop_count); else n_pass++;
`endif
    net_v = 1'b1;
    net_packet = mk(10'd5, 3'b011, 14'h2A, 32'd0);
    step();
    net_v = 1'b0;
    step();
    n_checks++; if (pc_wen !== 1'b1) $display("FAIL own_pc_wen got %b want 1", pc_wen); else n_pass++;
    n_checks++; if (pc !== 10'h2A) $display("FAIL own_pc got %h want 02a", pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] any;
    do_reset();
    core_id = 10'd5; core_state = 2'b00; rf_ready = 1'b0;
    net_v = 1'b1;
    net_packet = mk(10'd5, 3'b100, 14'h0, 32'h7);
    step();
    for (int i = 0; i < 3; i++) begin
      net_packet = mk(10'd5, 3'b010, 14'(i + 4), 32'hAB00 + 32'(i));
      step();
    end
    net_v = 1'b0;
    n_checks++; if (fifo_count !== 3'd3) $display("FAIL mid_count got %0d want 3", fifo_count); else n_pass++;
    n_checks++; if (bar_mask !== 3'b111) $display("FAIL mid_mask got %b want 111", bar_mask); else n_pass++;
    #2;
    n_reset = 1'b0;
    #1;
    n_checks++; if ({imem_wen, rf_wen, pc_wen, bar_wen} !== 4'b0) $display("FAIL mid_rst_wen got %b want 0000", {imem_wen, rf_wen, pc_wen, bar_wen}); else n_pass++;
    n_checks++; if (bar_mask !== 3'b0) $display("FAIL mid_rst_mask got %b want 000", bar_mask); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL mid_rst_count got %0d want 0", fifo_count); else n_pass++;
    rf_ready = 1'b1;
    #1;
    n_reset = 1'b1;
    any = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      any |= {imem_wen, rf_wen, pc_wen, bar_wen};
    end
    n_checks++; if (any !== 4'b0) $display("FAIL mid_stale_strobe got %b want 0000", any); else n_pass++;
    n_checks++; if ({fifo_count, net_ready} !== {3'd0, 1'b1}) $display("FAIL mid_after got %0d/%b want 0/1", fifo_count, net_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_filter();
    test_state_gating();
    test_full();
    test_saturation();
    test_broadcast();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
